// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants, FSM state encoding and small helpers for
//               the data-memory responder (dmem_resp / dmem_ram).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int BYTE_W = DATA_W / BE_W;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Per-lane write strobes: only stores write, and only the enabled lanes.
  function automatic logic [BE_W-1:0] lane_we(input logic we, input logic [BE_W-1:0] be);
    return be & {BE_W{we}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Synchronous single-port word memory built from one byte-wide
//               array per lane. One access per enabled cycle: lanes with their
//               write strobe set are written, and the old word is registered
//               onto o_rdata (read-first). Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic [BE_W-1:0]                i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [DATA_W-1:0]              i_wdata,
  output logic [DATA_W-1:0]              o_rdata
);

  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    logic [BYTE_W-1:0] r_mem [DEPTH_WORDS];
    logic [BYTE_W-1:0] r_q;

    // Byte lane: optional write plus registered read of the previous value.
    always_ff @(posedge clk) begin
      if (i_en) begin
        if (i_we[l]) begin
          r_mem[i_addr] <= i_wdata[l*BYTE_W +: BYTE_W];
        end
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[l*BYTE_W +: BYTE_W] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Data-memory responder with a valid/ready request channel and
//               a valid/ready response channel. Each access runs
//               IDLE -> WAIT (WAIT_CYCLES cycles, skipped when 0) -> RESP.
//               The memory is touched on the edge that enters RESP, so an
//               access aborted by reset never reaches storage.
//               Optional build macro: DMEM_RESP_ALIGN_CHECK_EN - flag any
//               access with a non-zero byte offset as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int         c_ADDR_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT    = 4'(WAIT_CYCLES);
  localparam bit         c_NO_WAIT = (WAIT_CYCLES == 0);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_rsp_load;
  logic [c_ADDR_W-1:0] r_idx;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_err;

  logic                w_accept;
  logic                w_req_oob;
  logic                w_req_misal;
  logic                w_req_err;
  logic [c_ADDR_W-1:0] w_req_idx;
  logic                w_go_now;
  logic                w_go_wait;
  logic                w_go;
  logic [c_ADDR_W-1:0] w_acc_idx;
  logic                w_acc_we;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [BE_W-1:0]     w_acc_be;
  logic                w_acc_err;
  logic                w_ram_en;
  logic [BE_W-1:0]     w_ram_we;
  logic [DATA_W-1:0]   w_ram_rdata;

  // Ready is only ever registered high in IDLE, so it doubles as the IDLE flag.
  assign w_accept  = req_valid_i & r_req_ready;
  assign w_req_oob = |req_addr_i[31:c_ADDR_W+2];
  assign w_req_idx = req_addr_i[c_ADDR_W+1:2];

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  assign w_req_misal = |req_addr_i[1:0];
`else
  // Byte offset is irrelevant for word accesses in this build.
  logic w_unused_offset;
  assign w_unused_offset = ^req_addr_i[1:0];
  assign w_req_misal     = 1'b0;
`endif

  assign w_req_err = w_req_oob | w_req_misal;

  // Memory access edge: the accept edge itself when there are no wait states,
  // otherwise the last WAIT cycle.
  assign w_go_now  = c_NO_WAIT & w_accept;
  assign w_go_wait = (r_state == ST_WAIT) && (r_cnt == 4'd1);
  assign w_go      = w_go_now | w_go_wait;

  // With no wait states the access uses the live request, else the latched copy.
  assign w_acc_idx   = w_go_now ? w_req_idx   : r_idx;
  assign w_acc_we    = w_go_now ? req_we_i    : r_we;
  assign w_acc_wdata = w_go_now ? req_wdata_i : r_wdata;
  assign w_acc_be    = w_go_now ? req_be_i    : r_be;
  assign w_acc_err   = w_go_now ? w_req_err   : r_err;

  // Errored accesses never reach storage; loads ignore the byte enables.
  assign w_ram_en = w_go & ~w_acc_err;
  assign w_ram_we = lane_we(w_acc_we, w_acc_be);

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Request/response sequencing with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_idx       <= w_req_idx;
            r_we        <= req_we_i;
            r_wdata     <= req_wdata_i;
            r_be        <= req_be_i;
            r_err       <= w_req_err;
            if (c_NO_WAIT) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_acc_err;
              r_rsp_load  <= ~w_acc_we & ~w_acc_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= c_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_go_wait) begin
            r_state     <= ST_RESP;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_acc_err;
            r_rsp_load  <= ~w_acc_we & ~w_acc_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_load  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  // Memory read register holds its value outside access edges; zero it for
  // stores, errors and whenever no load response is being presented.
  assign rsp_rdata_o = w_ram_rdata & {DATA_W{r_rsp_load}};

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Self-checking bench for dmem_resp. Three instances with
//               WAIT_CYCLES = 1, 3 and 0 share one clock. A word-level
//               reference memory (associative array) predicts load data,
//               errors and response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;
  localparam int BOUND = 40;
  localparam int c_W [NI] = '{1, 3, 0};

  logic        clk = 1'b0;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: key = instance*65536 + word index.
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_resp #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_be_i    (req_be[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] addr);
    bit e;
    e = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  // One full transaction on instance k; responses held for 'hold' extra cycles.
  task automatic access(input int k, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold);
    bit          e_err;
    logic [31:0] e_rd;
    logic [31:0] old;
    int          key;
    int          n;
    e_err = ref_err(addr);
    key   = k * 65536 + int'(addr[11:2]);
    e_rd  = 32'h0;
    if (!we && !e_err) e_rd = mdl.exists(key) ? mdl[key] : 32'h0;
    n = 0;
    while (!req_ready[k] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready[k]}, 32'h1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    while (!rsp_valid[k] && n < BOUND) begin
      chk("req_ready_busy", {31'b0, req_ready[k]}, 32'h0);
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(c_W[k] + 1));
    chk("rsp_err", {31'b0, rsp_err[k]}, {31'b0, e_err});
    chk("rsp_rdata", rsp_rdata[k], e_rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid[k]}, 32'h1);
      chk("hold_rdata", rsp_rdata[k], e_rd);
      chk("hold_ready", {31'b0, req_ready[k]}, 32'h0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk("ready_after_hs", {31'b0, req_ready[k]}, 32'h1);
    chk("valid_after_hs", {31'b0, rsp_valid[k]}, 32'h0);
    if (we && !e_err) begin
      old = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (be[b]) old[b*8 +: 8] = wdata[b*8 +: 8];
      mdl[key] = old;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          acc_cnt;
    int          vld_cnt;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", {31'b0, req_ready[k]}, 32'h0);
      chk("rst_valid", {31'b0, rsp_valid[k]}, 32'h0);
      chk("rst_rdata", rsp_rdata[k], 32'h0);
      chk("rst_err", {31'b0, rsp_err[k]}, 32'h0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("ready_after_rst", {31'b0, req_ready[k]}, 32'h1);

    // Full-word store then load, partial-lane store then load.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("dir_load_full", mdl[16'h4], 32'hDEADBEEF);
    access(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    access(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, 0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    chk("dir_load_lane", mdl[16'h4], 32'hDEADBEAA);

    // Out of range (and misaligned when the check is built in).
    access(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1);
    access(0, 1'b1, 32'hFFFF_FFF0, 32'h55555555, 4'hF, 0);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    access(0, 1'b1, 32'h12, 32'h11111111, 4'hF, 0);
`else
    access(0, 1'b1, 32'h16, 32'h11111111, 4'hF, 0);
`endif
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    access(0, 1'b0, 32'h14, 32'h0, 4'h0, 0);

    // Randomized traffic on every instance over a seeded window of words.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) access(k, 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 0);
      for (int i = 0; i < ((k == 0) ? 40 : 12); i++) begin
        if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 100000));
        else a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        access(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3));
      end
    end

    // Reset during WAIT discards the store (WAIT_CYCLES = 3 instance).
    access(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'hCAFEF00D; req_be[1] = 4'hF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, rsp_valid[1]}, 32'h0);
    chk("midrst_ready", {31'b0, req_ready[1]}, 32'h0);
    chk("midrst_rdata", rsp_rdata[1], 32'h0);
    repeat (2) @(negedge clk);
    chk("inrst_valid", {31'b0, rsp_valid[1]}, 32'h0);
    rst_n[1] = 1'b1;
    #1;
    chk("deassert_ready", {31'b0, req_ready[1]}, 32'h0);
    @(negedge clk);
    chk("postrst_ready", {31'b0, req_ready[1]}, 32'h1);
    chk("postrst_valid", {31'b0, rsp_valid[1]}, 32'h0);
    access(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("rst_store_dropped", mdl[65536 + 8], 32'h11223344);

    // Back-to-back loads with zero wait states: one accept every 2 cycles.
    access(2, 1'b1, 32'h10, 32'hA5A5_0F0F, 4'hF, 0);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h10; req_be[2] = 4'h0;
    rsp_ready[2] = 1'b1;
    acc_cnt = 0;
    vld_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      chk("b2b_ready_pattern", {31'b0, req_ready[2]}, {31'b0, c[0] == 1'b0});
      if (req_ready[2]) acc_cnt++;
      if (rsp_valid[2]) begin
        vld_cnt++;
        chk("b2b_rdata", rsp_rdata[2], mdl[2 * 65536 + 4]);
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    chk("b2b_accepts", 32'(acc_cnt), 32'd5);
    chk("b2b_responses", 32'(vld_cnt), 32'd5);
    @(negedge clk);
    rsp_ready[2] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
